// File: rtl/countdown_sequencer_pkg.sv
// Shared definitions for the countdown sequencer: state encoding, default
// parameters, the per-cycle button event bundle and small datapath helpers.
package countdown_sequencer_pkg;

    // FSM state encoding; the values are fixed so debug probes can decode them.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        FIN   = 2'd3
    } state_t;

    // 100 MHz board clock -> one tick per half second.
    localparam int HALF_TICKS_DEFAULT = 50000000;
    // Two halves per add press, i.e. one whole unit.
    localparam int ADD_HALVES_DEFAULT = 2;
    // 31 halves = 15.5, the largest value the 5-bit val bus can show.
    localparam int MAX_HALVES_DEFAULT = 31;

    // One single-cycle event per button press, already edge-detected.
    typedef struct packed {
        logic clear;
        logic start;
        logic pause;
        logic add;
    } btn_events_t;

    // Add with saturation at the configured ceiling.
    function automatic logic [4:0] sat_add(input logic [4:0] halves,
                                           input logic [4:0] inc,
                                           input logic [4:0] limit);
        logic [5:0] sum;
        sum = {1'b0, halves} + {1'b0, inc};
        if (sum > {1'b0, limit}) begin
            return limit;
        end
        return sum[4:0];
    endfunction

    // Half-unit count to display format: {half flag, whole units}.
    function automatic logic [4:0] halves_to_val(input logic [4:0] halves);
        return {halves[0], halves[4:1]};
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Button conditioner: two-flop synchronizer for an asynchronous raw level,
// followed by a rising-edge detector producing a one-cycle pulse.
// A level sampled high at edge k shows up as a pulse in the cycle after k+1,
// so whatever consumes the pulse reacts on edge k+2.
module btn_edge (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic pulse
);

    logic sync_a;
    logic sync_b;
    logic prev;

    // Synchronize the raw level and remember its previous synchronized value.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            prev   <= 1'b0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
            prev   <= sync_b;
        end
    end

    // A held button produces exactly one pulse on its synchronized rising edge.
    assign pulse = sync_b & ~prev;

endmodule

// File: rtl/countdown_sequencer.sv
// Countdown control stage feeding the seven-segment printers.
// Holds a half-unit count, decrements it every HALF_TICKS cycles while
// running, and selects exactly one of the hello/digit/fin printers.
//
// Button handshake: each raw button is a free-running level with no
// acknowledge; a press is the synchronized rising edge, seen as one event.
// Events in the same cycle resolve clear > start > pause > add and only the
// winner acts (a losing event is dropped, not deferred).
module countdown_sequencer
    import countdown_sequencer_pkg::*;
#(
    parameter int HALF_TICKS = HALF_TICKS_DEFAULT,
    parameter int ADD_HALVES = ADD_HALVES_DEFAULT,
    parameter int MAX_HALVES = MAX_HALVES_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start_btn,
    input  logic       pause_btn,
    input  logic       add_btn,
    input  logic       clear_btn,
    output logic [4:0] val,
    output logic       hello_en,
    output logic       digit_en,
    output logic       fin_en,
    output logic       running
);

    localparam int PRE_W = (HALF_TICKS > 2) ? $clog2(HALF_TICKS) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(HALF_TICKS - 1);
    localparam logic [4:0]       ADD_INC   = 5'(ADD_HALVES);
    localparam logic [4:0]       HALVES_MX = 5'(MAX_HALVES);

    btn_events_t      ev;
    state_t           state;
    state_t           state_n;
    logic [4:0]       halves;
    logic [4:0]       halves_n;
    logic [PRE_W-1:0] pre;
    logic [PRE_W-1:0] pre_n;
    logic             tick;

    btn_edge u_clear (.clock(clock), .reset(reset), .raw(clear_btn), .pulse(ev.clear));
    btn_edge u_start (.clock(clock), .reset(reset), .raw(start_btn), .pulse(ev.start));
    btn_edge u_pause (.clock(clock), .reset(reset), .raw(pause_btn), .pulse(ev.pause));
    btn_edge u_add   (.clock(clock), .reset(reset), .raw(add_btn),   .pulse(ev.add));

    // Next-state, next-count and prescaler decisions for the coming edge.
    always_comb begin
        state_n  = state;
        halves_n = halves;
        pre_n    = pre;
        tick     = 1'b0;

        if (ev.clear) begin
            // Clear beats everything, including a tick due on this edge.
            state_n  = IDLE;
            halves_n = 5'd0;
            pre_n    = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ev.start) begin
                        // Starting from zero would immediately finish; ignore it.
                        if (halves != 5'd0) begin
                            state_n = RUN;
                            pre_n   = '0;
                        end
                    end else if (ev.pause) begin
                        // Nothing to pause; the event is consumed and dropped.
                        state_n = IDLE;
                    end else if (ev.add) begin
                        halves_n = sat_add(halves, ADD_INC, HALVES_MX);
                    end
                end

                RUN: begin
                    // The prescaler advances on every RUN edge, including the
                    // edge that leaves for PAUSE, so a pause never loses a cycle
                    // of accumulated time.
                    tick  = (pre == PRE_LAST);
                    pre_n = tick ? '0 : pre + PRE_W'(1);
                    if (tick && halves != 5'd0) begin
                        halves_n = halves - 5'd1;
                    end
                    if (tick && halves <= 5'd1) begin
                        // Reaching zero finishes even if pause arrives together.
                        state_n = FIN;
                    end else if (ev.start) begin
                        // Start outranks pause but does nothing while running.
                        state_n = RUN;
                    end else if (ev.pause) begin
                        state_n = PAUSE;
                    end
                end

                PAUSE: begin
                    // Prescaler frozen; resume continues from the held phase.
                    if (ev.start) begin
                        state_n = RUN;
                    end else if (ev.pause) begin
                        state_n = PAUSE;
                    end else if (ev.add) begin
                        halves_n = sat_add(halves, ADD_INC, HALVES_MX);
                    end
                end

                FIN: begin
                    halves_n = 5'd0;
                    if (ev.start) begin
                        state_n = IDLE;
                    end
                end

                default: begin
                    state_n  = IDLE;
                    halves_n = 5'd0;
                    pre_n    = '0;
                end
            endcase
        end
    end

    // FSM and datapath registers; outputs are registered from the next values
    // so they line up with the state they describe on the same edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            halves   <= 5'd0;
            pre      <= '0;
            val      <= 5'd0;
            hello_en <= 1'b1;
            digit_en <= 1'b0;
            fin_en   <= 1'b0;
            running  <= 1'b0;
        end else begin
            state    <= state_n;
            halves   <= halves_n;
            pre      <= pre_n;
            val      <= halves_to_val(halves_n);
            hello_en <= (state_n == IDLE) && (halves_n == 5'd0);
            digit_en <= ((state_n == IDLE) && (halves_n != 5'd0)) ||
                        (state_n == RUN) || (state_n == PAUSE);
            fin_en   <= (state_n == FIN);
            running  <= (state_n == RUN);
        end
    end

endmodule

// File: tb/tb_countdown_sequencer.sv
// Self-checking bench for countdown_sequencer with HALF_TICKS=4.
module tb_countdown_sequencer;

    localparam int HT   = 4;
    localparam int ADD  = 2;
    localparam int MAXH = 31;

    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;
    localparam int S_FIN   = 3;

    // btn[0]=start btn[1]=pause btn[2]=add btn[3]=clear
    logic       clock;
    logic       reset;
    logic [3:0] btn;
    logic [4:0] val;
    logic       hello_en;
    logic       digit_en;
    logic       fin_en;
    logic       running;
    logic [8:0] dut_bus;

    int checks = 0;
    int errors = 0;
    logic [4:0] exp_q[$];

    countdown_sequencer #(.HALF_TICKS(HT), .ADD_HALVES(ADD), .MAX_HALVES(MAXH)) dut (
        .clock    (clock),
        .reset    (reset),
        .start_btn(btn[0]),
        .pause_btn(btn[1]),
        .add_btn  (btn[2]),
        .clear_btn(btn[3]),
        .val      (val),
        .hello_en (hello_en),
        .digit_en (digit_en),
        .fin_en   (fin_en),
        .running  (running)
    );

    assign dut_bus = {val, hello_en, digit_en, fin_en, running};

    // ---------------- clock ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    // Time is tracked as plain integers: halves left, run cycles into the
    // current half, and a mode number. A button level sampled at edge k acts at k+2.
    int         m_state;
    int         m_h;
    int         m_p;
    logic [3:0] r1, r2, r3;
    logic [3:0] m_ev;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_state = S_IDLE; m_h = 0; m_p = 0;
            r1 = 4'd0; r2 = 4'd0; r3 = 4'd0;
        end else begin
            m_ev = r2 & ~r3;
            if (m_ev[3]) begin
                m_state = S_IDLE; m_h = 0; m_p = 0;
            end else if (m_state == S_RUN) begin
                m_p = m_p + 1;
                if (m_p == HT) begin
                    m_p = 0;
                    if (m_h > 0) m_h = m_h - 1;
                end
                if (m_h == 0) m_state = S_FIN;
                else if (!m_ev[0] && m_ev[1]) m_state = S_PAUSE;
            end else if (m_state == S_IDLE) begin
                if (m_ev[0]) begin
                    if (m_h > 0) begin m_state = S_RUN; m_p = 0; end
                end else if (!m_ev[1] && m_ev[2]) begin
                    m_h = (m_h + ADD > MAXH) ? MAXH : m_h + ADD;
                end
            end else if (m_state == S_PAUSE) begin
                if (m_ev[0]) m_state = S_RUN;
                else if (!m_ev[1] && m_ev[2]) m_h = (m_h + ADD > MAXH) ? MAXH : m_h + ADD;
            end else begin
                m_h = 0;
                if (m_ev[0]) m_state = S_IDLE;
            end
            r3 = r2; r2 = r1; r1 = btn;
        end
    end

    function automatic logic [4:0] val_of(input int h);
        return 5'(((h % 2) * 16) + (h / 2));
    endfunction

    function automatic logic [8:0] model_bus();
        logic hello, digit, fin, run;
        hello = (m_state == S_IDLE) && (m_h == 0);
        digit = ((m_state == S_IDLE) && (m_h > 0)) || (m_state == S_RUN) || (m_state == S_PAUSE);
        fin   = (m_state == S_FIN);
        run   = (m_state == S_RUN);
        return {val_of(m_h), hello, digit, fin, run};
    endfunction

    // ---------------- drivers ----------------
    task automatic press(input int b);
        @(negedge clock); btn[b] = 1'b1;
        @(negedge clock); btn[b] = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1; btn = 4'd0;
        idle_cycles(2);
        checks++; if (hello_en !== 1'b1) begin errors++; $display("FAIL reset_hello: got %b want 1", hello_en); end
        checks++; if (digit_en !== 1'b0) begin errors++; $display("FAIL reset_digit: got %b want 0", digit_en); end
        checks++; if (fin_en !== 1'b0) begin errors++; $display("FAIL reset_fin: got %b want 0", fin_en); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running: got %b want 0", running); end
        checks++; if (val !== 5'b00000) begin errors++; $display("FAIL reset_val: got %b want 00000", val); end
        reset = 1'b0;
        repeat (5) begin
            @(negedge clock);
            checks++; if (dut_bus !== model_bus()) begin errors++; $display("FAIL reset_idle_bus: got %b want %b", dut_bus, model_bus()); end
        end
    endtask

    task automatic test_add();
        press(3); idle_cycles(3);
        repeat (3) begin
            press(2); idle_cycles(1);
            checks++; if (dut_bus !== model_bus()) begin errors++; $display("FAIL add_step_bus: got %b want %b", dut_bus, model_bus()); end
        end
        idle_cycles(2);
        checks++; if (val !== 5'b00011) begin errors++; $display("FAIL add_three_val: got %b want 00011", val); end
        checks++; if (digit_en !== 1'b1) begin errors++; $display("FAIL add_three_digit: got %b want 1", digit_en); end
        repeat (20) begin
            press(2);
            checks++; if (dut_bus !== model_bus()) begin errors++; $display("FAIL add_sat_bus: got %b want %b", dut_bus, model_bus()); end
        end
        idle_cycles(3);
        checks++; if (val !== 5'b11111) begin errors++; $display("FAIL add_saturate_val: got %b want 11111", val); end
    endtask

    task automatic test_countdown();
        press(3); idle_cycles(3);
        repeat (3) press(2);
        idle_cycles(3);
        press(0);
        @(posedge clock); @(posedge clock);
        for (int c = 0; c <= 24; c++) exp_q.push_back(val_of(6 - c / 4));
        for (int c = 0; c <= 24; c++) begin
            logic [4:0] e;
            @(negedge clock);
            e = exp_q.pop_front();
            checks++; if (val !== e) begin errors++; $display("FAIL countdown_val c=%0d: got %b want %b", c, val, e); end
            checks++; if (dut_bus !== model_bus()) begin errors++; $display("FAIL countdown_bus c=%0d: got %b want %b", c, dut_bus, model_bus()); end
            if (c == 23) begin
                checks++; if (fin_en !== 1'b0) begin errors++; $display("FAIL countdown_early_fin: got %b want 0", fin_en); end
            end
            if (c == 24) begin
                checks++; if (fin_en !== 1'b1) begin errors++; $display("FAIL countdown_fin: got %b want 1", fin_en); end
                checks++; if (running !== 1'b0) begin errors++; $display("FAIL countdown_running: got %b want 0", running); end
            end
        end
    endtask

    task automatic test_pause();
        press(3); idle_cycles(3);
        repeat (3) press(2);
        idle_cycles(3);
        press(0);
        @(posedge clock); @(posedge clock);
        // pause level sampled at start+8 so the pause acts at start+10
        repeat (8) @(negedge clock);
        btn[1] = 1'b1;
        @(negedge clock); btn[1] = 1'b0;
        idle_cycles(2);
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL pause_running: got %b want 0", running); end
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            checks++; if (val !== 5'b00010) begin errors++; $display("FAIL pause_frozen i=%0d: got %b want 00010", i, val); end
            checks++; if (dut_bus !== model_bus()) begin errors++; $display("FAIL pause_bus i=%0d: got %b want %b", i, dut_bus, model_bus()); end
        end
        press(0);
        @(posedge clock); @(posedge clock);
        repeat (14) @(negedge clock);
        checks++; if (fin_en !== 1'b0) begin errors++; $display("FAIL resume_early_fin: got %b want 0", fin_en); end
        @(negedge clock);
        checks++; if (fin_en !== 1'b1) begin errors++; $display("FAIL resume_fin: got %b want 1", fin_en); end
        checks++; if (val !== 5'b00000) begin errors++; $display("FAIL resume_val: got %b want 00000", val); end
    endtask

    task automatic test_clear_wins();
        press(3); idle_cycles(3);
        repeat (2) press(2);
        press(0); idle_cycles(3);
        press(1); idle_cycles(3);
        checks++; if (running !== 1'b0 || digit_en !== 1'b1) begin errors++; $display("FAIL clear_setup_pause: got run=%b digit=%b want 0 1", running, digit_en); end
        @(negedge clock); btn[3] = 1'b1; btn[0] = 1'b1;
        @(negedge clock); btn[3] = 1'b0; btn[0] = 1'b0;
        idle_cycles(3);
        checks++; if (hello_en !== 1'b1) begin errors++; $display("FAIL clear_wins_hello: got %b want 1", hello_en); end
        checks++; if (val !== 5'b00000 || running !== 1'b0) begin errors++; $display("FAIL clear_wins_val: got %b run=%b want 00000 0", val, running); end
        checks++; if (dut_bus !== model_bus()) begin errors++; $display("FAIL clear_wins_bus: got %b want %b", dut_bus, model_bus()); end
    endtask

    task automatic test_start_zero_fin_hold();
        bit seen;
        press(3); idle_cycles(3);
        press(0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            checks++; if (hello_en !== 1'b1 || running !== 1'b0) begin errors++; $display("FAIL start_zero_ignored i=%0d: got hello=%b run=%b want 1 0", i, hello_en, running); end
        end
        press(2); press(0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            checks++; if (dut_bus !== model_bus()) begin errors++; $display("FAIL fin_wait_bus: got %b want %b", dut_bus, model_bus()); end
            if (fin_en === 1'b1) begin seen = 1'b1; break; end
        end
        checks++; if (!seen) begin errors++; $display("FAIL fin_timeout: got fin_en=%b want 1 within 40 cycles", fin_en); end
        press(0); idle_cycles(3);
        checks++; if (hello_en !== 1'b1 || fin_en !== 1'b0) begin errors++; $display("FAIL fin_ack: got hello=%b fin=%b want 1 0", hello_en, fin_en); end
        @(negedge clock); btn[2] = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            checks++; if (dut_bus !== model_bus()) begin errors++; $display("FAIL hold_add_bus i=%0d: got %b want %b", i, dut_bus, model_bus()); end
        end
        btn[2] = 1'b0;
        idle_cycles(3);
        checks++; if (val !== 5'b00001) begin errors++; $display("FAIL hold_add_once: got %b want 00001", val); end
    endtask

    task automatic test_reset_mid_run();
        bit seen;
        press(3); idle_cycles(3);
        repeat (5) press(2);
        press(0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (m_state == S_RUN && m_h == 9) begin seen = 1'b1; break; end
        end
        checks++; if (!seen || val !== 5'b10100) begin errors++; $display("FAIL midrun_setup: got val=%b want 10100", val); end
        reset = 1'b1;
        #1;
        checks++; if (hello_en !== 1'b1) begin errors++; $display("FAIL midrun_reset_hello: got %b want 1", hello_en); end
        checks++; if (val !== 5'b00000) begin errors++; $display("FAIL midrun_reset_val: got %b want 00000", val); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL midrun_reset_running: got %b want 0", running); end
        @(negedge clock); reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            checks++; if (hello_en !== 1'b1 || running !== 1'b0) begin errors++; $display("FAIL midrun_idle_hold i=%0d: got hello=%b run=%b want 1 0", i, hello_en, running); end
        end
    endtask

    task automatic test_random();
        press(3); idle_cycles(3);
        for (int i = 0; i < 1500; i++) begin
            @(negedge clock);
            checks++; if (dut_bus !== model_bus()) begin errors++; $display("FAIL random_bus i=%0d: got %b want %b", i, dut_bus, model_bus()); end
            checks++; if (!$onehot({hello_en, digit_en, fin_en})) begin errors++; $display("FAIL random_onehot i=%0d: got %b%b%b want one-hot", i, hello_en, digit_en, fin_en); end
            case ($urandom_range(0, 3))
                0: begin
                    case ($urandom_range(0, 11))
                        0, 1, 2, 3, 4: btn = 4'b0100;
                        5, 6, 7:       btn = 4'b0001;
                        8, 9:          btn = 4'b0010;
                        10:            btn = 4'b1000;
                        default:       btn = 4'($urandom_range(0, 15));
                    endcase
                end
                1: btn = 4'b0000;
                default: btn = btn;
            endcase
        end
        btn = 4'b0000;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        btn = 4'd0;
        test_reset();
        test_add();
        test_countdown();
        test_pause();
        test_clear_wins();
        test_start_zero_fin_hold();
        test_reset_mid_run();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
